// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multiport register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_clear_sequencer.sv
// Control FSM that sweeps zeros through registers 1..NUM_REGS-1 after reset or a clear request.
module regfile_clear_sequencer
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic                  i_Clear,
    output logic                  o_SweepWe,
    output logic [ADDR_WIDTH-1:0] o_SweepIdx,
    output logic                  o_Ready
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;

    state_t                r_State;
    logic [ADDR_WIDTH-1:0] r_SweepIdx;
    logic                  r_Ready;

    // Index saturates at LAST_IDX when leaving CLEAR; a clear request inside CLEAR is ignored.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_State    <= CLEAR;
            r_SweepIdx <= FIRST_IDX;
            r_Ready    <= 1'b0;
        end else begin
            case (r_State)
                CLEAR: begin
                    if (r_SweepIdx == LAST_IDX) begin
                        r_State <= READY;
                        r_Ready <= 1'b1;
                    end else begin
                        r_SweepIdx <= r_SweepIdx + 1'b1;
                    end
                end
                READY: begin
                    if (i_Clear) begin
                        r_State    <= CLEAR;
                        r_SweepIdx <= FIRST_IDX;
                        r_Ready    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_SweepWe  = (r_State == CLEAR);
    assign o_SweepIdx = r_SweepIdx;
    assign o_Ready    = r_Ready;

endmodule

// File: rtl/multiport_register_file.sv
// Two-write, N-read register file with write-first bypass, hard-wired zero register and sweep clear.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int NUM_READ_PORTS = 2
) (
    input  logic                                       i_Clock,
    input  logic                                       i_Reset_n,
    input  logic                                       i_WriteEnable0,
    input  logic                                       i_WriteEnable1,
    input  logic [ADDR_WIDTH-1:0]                      i_RegDest0,
    input  logic [ADDR_WIDTH-1:0]                      i_RegDest1,
    input  logic [DATA_WIDTH-1:0]                      i_DataIn0,
    input  logic [DATA_WIDTH-1:0]                      i_DataIn1,
    input  logic [NUM_READ_PORTS-1:0]                  i_ReadEnable,
    input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]  i_RegSource,
    input  logic                                       i_Clear,
    output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]  o_DataOut,
    output logic                                       o_Ready
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]                     r_Mem [1:NUM_REGS-1];
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] r_DataOut;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] w_ReadData;
    logic                                      w_SweepWe;
    logic [ADDR_WIDTH-1:0]                     w_SweepIdx;
    logic                                      w_Ready;
    logic                                      w_Wr0;
    logic                                      w_Wr1;

    regfile_clear_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ClearSeq (
        .i_Clock    (i_Clock),
        .i_Reset_n  (i_Reset_n),
        .i_Clear    (i_Clear),
        .o_SweepWe  (w_SweepWe),
        .o_SweepIdx (w_SweepIdx),
        .o_Ready    (w_Ready)
    );

    assign w_Wr0 = w_Ready && i_WriteEnable0 && (i_RegDest0 != '0);
    assign w_Wr1 = w_Ready && i_WriteEnable1 && (i_RegDest1 != '0);

    // Port 1 is written last so it wins on an address collision.
    always_ff @(posedge i_Clock) begin
        if (i_Reset_n) begin
            if (w_SweepWe) begin
                r_Mem[w_SweepIdx] <= '0;
            end else begin
                if (w_Wr0) r_Mem[i_RegDest0] <= i_DataIn0;
                if (w_Wr1) r_Mem[i_RegDest1] <= i_DataIn1;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            w_ReadData[p] = '0;
            if (w_Ready && (i_RegSource[p] != '0)) begin
                if (w_Wr1 && (i_RegDest1 == i_RegSource[p])) begin
                    w_ReadData[p] = i_DataIn1;
                end else if (w_Wr0 && (i_RegDest0 == i_RegSource[p])) begin
                    w_ReadData[p] = i_DataIn0;
                end else begin
                    w_ReadData[p] = r_Mem[i_RegSource[p]];
                end
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_DataOut <= '0;
        end else begin
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                if (i_ReadEnable[p]) r_DataOut[p] <= w_ReadData[p];
            end
        end
    end

    assign o_DataOut = r_DataOut;
    assign o_Ready   = w_Ready;

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: an abstract register-file model checked every cycle plus literal expectations.
module tb_multiport_register_file;

    logic             clk = 1'b0;
    logic             rstn;
    logic             we0, we1;
    logic [4:0]       dest0, dest1;
    logic [31:0]      din0, din1;
    logic [1:0]       readEn;
    logic [1:0][4:0]  regSrc;
    logic             clr;
    logic [1:0][31:0] dataOut;
    logic             ready;

    int nChecks = 0;
    int nErrors = 0;
    int lowCount;

    multiport_register_file #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (5),
        .NUM_READ_PORTS (2)
    ) dut (
        .i_Clock        (clk),
        .i_Reset_n      (rstn),
        .i_WriteEnable0 (we0),
        .i_WriteEnable1 (we1),
        .i_RegDest0     (dest0),
        .i_RegDest1     (dest1),
        .i_DataIn0      (din0),
        .i_DataIn1      (din1),
        .i_ReadEnable   (readEn),
        .i_RegSource    (regSrc),
        .i_Clear        (clr),
        .o_DataOut      (dataOut),
        .o_Ready        (ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Model: clearing lasts 31 edges, reads zero, ignores writes; afterwards every register is zero.
    logic [31:0] mMem [32];
    logic [31:0] mOut [2];
    logic        mReady = 1'b0;
    logic        mValid = 1'b0;
    int          mLeft  = 0;

    initial for (int i = 0; i < 32; i++) mMem[i] = '0;

    always @(posedge clk) begin
        if (!rstn) begin
            mOut[0] = '0;
            mOut[1] = '0;
            mReady  = 1'b0;
            mLeft   = 31;
            mValid  = 1'b1;
        end else if (mValid) begin
            if (!mReady) begin
                for (int p = 0; p < 2; p++) if (readEn[p]) mOut[p] = '0;
                mLeft--;
                if (mLeft == 0) begin
                    mReady = 1'b1;
                    for (int i = 0; i < 32; i++) mMem[i] = '0;
                end
            end else begin
                if (we0 && dest0 != 0) mMem[dest0] = din0;
                if (we1 && dest1 != 0) mMem[dest1] = din1;
                for (int p = 0; p < 2; p++) if (readEn[p]) mOut[p] = mMem[regSrc[p]];
                if (clr) begin
                    mReady = 1'b0;
                    mLeft  = 31;
                end
            end
        end
        #1;
        if (mValid) begin
            checkOutput("model_ready", {31'b0, ready}, {31'b0, mReady});
            checkOutput("model_out0", dataOut[0], mOut[0]);
            checkOutput("model_out1", dataOut[1], mOut[1]);
        end
    end

    task automatic setIdle();
        rstn   = 1'b1;
        we0    = 1'b0;
        we1    = 1'b0;
        dest0  = '0;
        dest1  = '0;
        din0   = '0;
        din1   = '0;
        readEn = '0;
        regSrc = '0;
        clr    = 1'b0;
    endtask

    // Inputs change 2 time units after an edge; returning here means the DUT has taken them.
    task automatic applyStimulus();
        @(posedge clk);
        #2;
    endtask

    task automatic countUntilReady(output int cycles);
        cycles = 0;
        while (!ready && cycles < 100) begin
            applyStimulus();
            cycles++;
        end
    endtask

    initial begin
        setIdle();
        rstn = 1'b0;
        we0 = 1'b1; dest0 = 5'd6; din0 = 32'h99; readEn = 2'b11;
        applyStimulus();
        checkOutput("reset_ready", {31'b0, ready}, 32'd0);
        checkOutput("reset_out0", dataOut[0], 32'd0);
        checkOutput("reset_out1", dataOut[1], 32'd0);

        setIdle();
        readEn = 2'b01; regSrc[0] = 5'd5;
        countUntilReady(lowCount);
        checkOutput("startup_sweep_len", lowCount, 32'd31);
        applyStimulus();
        checkOutput("read_x5_after_sweep", dataOut[0], 32'd0);

        setIdle();
        we0 = 1'b1; dest0 = 5'd3; din0 = 32'hDEADBEEF;
        applyStimulus();
        setIdle();
        readEn = 2'b01; regSrc[0] = 5'd3;
        applyStimulus();
        checkOutput("read_x3", dataOut[0], 32'hDEADBEEF);

        setIdle();
        we0 = 1'b1; dest0 = 5'd0; din0 = 32'h1234; readEn = 2'b10; regSrc[1] = 5'd0;
        applyStimulus();
        checkOutput("x0_bypass_zero", dataOut[1], 32'd0);
        setIdle();
        readEn = 2'b10; regSrc[1] = 5'd0;
        applyStimulus();
        checkOutput("read_x0", dataOut[1], 32'd0);

        setIdle();
        we0 = 1'b1; dest0 = 5'd7; din0 = 32'h11;
        we1 = 1'b1; dest1 = 5'd7; din1 = 32'h22;
        readEn = 2'b10; regSrc[1] = 5'd7;
        applyStimulus();
        checkOutput("collide_bypass_p1", dataOut[1], 32'h22);
        setIdle();
        readEn = 2'b01; regSrc[0] = 5'd7;
        applyStimulus();
        checkOutput("collide_stored", dataOut[0], 32'h22);

        setIdle();
        we0 = 1'b1; dest0 = 5'd12; din0 = 32'hA5A5; readEn = 2'b01; regSrc[0] = 5'd12;
        applyStimulus();
        checkOutput("bypass_p0", dataOut[0], 32'hA5A5);

        setIdle();
        we0 = 1'b1; dest0 = 5'd20; din0 = 32'h1;
        we1 = 1'b1; dest1 = 5'd21; din1 = 32'h2;
        applyStimulus();
        setIdle();
        readEn = 2'b11; regSrc[0] = 5'd20; regSrc[1] = 5'd21;
        applyStimulus();
        checkOutput("dual_write_x20", dataOut[0], 32'h1);
        checkOutput("dual_write_x21", dataOut[1], 32'h2);

        setIdle();
        we0 = 1'b1; dest0 = 5'd4; din0 = 32'hAB; readEn = 2'b01; regSrc[0] = 5'd4;
        applyStimulus();
        setIdle();
        we0 = 1'b1; dest0 = 5'd4; din0 = 32'hCD; regSrc[0] = 5'd4;
        applyStimulus();
        checkOutput("hold_when_disabled", dataOut[0], 32'hAB);
        setIdle();
        readEn = 2'b01; regSrc[0] = 5'd4;
        applyStimulus();
        checkOutput("read_x4_new", dataOut[0], 32'hCD);

        setIdle();
        we0 = 1'b1; dest0 = 5'd9; din0 = 32'h55;
        applyStimulus();
        setIdle();
        clr = 1'b1; we1 = 1'b1; dest1 = 5'd9; din1 = 32'h77; readEn = 2'b10; regSrc[1] = 5'd9;
        applyStimulus();
        checkOutput("clear_cycle_write_bypass", dataOut[1], 32'h77);
        checkOutput("ready_drops_after_clear", {31'b0, ready}, 32'd0);
        setIdle();
        clr = 1'b1; we0 = 1'b1; dest0 = 5'd9; din0 = 32'h66; readEn = 2'b01; regSrc[0] = 5'd9;
        applyStimulus();
        checkOutput("read_during_clear", dataOut[0], 32'd0);
        lowCount = 1;
        setIdle();
        clr = 1'b1;
        while (!ready && lowCount < 100) begin
            applyStimulus();
            lowCount++;
        end
        checkOutput("clear_sweep_len", lowCount, 32'd31);
        setIdle();
        readEn = 2'b11; regSrc[0] = 5'd9; regSrc[1] = 5'd7;
        applyStimulus();
        checkOutput("x9_after_clear", dataOut[0], 32'd0);
        checkOutput("x7_after_clear", dataOut[1], 32'd0);

        setIdle();
        we0 = 1'b1; dest0 = 5'd3; din0 = 32'hBEEF;
        applyStimulus();
        setIdle();
        readEn = 2'b01; regSrc[0] = 5'd3;
        applyStimulus();
        setIdle();
        clr = 1'b1;
        applyStimulus();
        setIdle();
        for (int i = 0; i < 9; i++) applyStimulus();
        checkOutput("held_before_midreset", dataOut[0], 32'hBEEF);
        rstn = 1'b0;
        applyStimulus();
        checkOutput("midreset_out0", dataOut[0], 32'd0);
        setIdle();
        countUntilReady(lowCount);
        checkOutput("midreset_sweep_len", lowCount, 32'd31);
        setIdle();
        readEn = 2'b01; regSrc[0] = 5'd21;
        applyStimulus();
        checkOutput("x21_after_midreset", dataOut[0], 32'd0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
